// File: rtl/pic_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pic_cmd_sequencer
//
// Command-word sequencer for an 8259-style PIC. It watches CPU write cycles and
// follows the ICW1 -> ICW2 -> (ICW3) -> (ICW4) initialization order. After
// initialization it decodes OCW1/OCW2/OCW3. The resulting command address
// tells the data bus buffer which register to load while the strobe is low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   wrn        in   CPU write strobe, active low
//   CSn        in   chip select, active low
//   A0         in   CPU address bit 0
//   din[7:0]   in   CPU data bus
//   cadr[2:0]  out  command address
//                   000 none, 001 ICW1, 010 ICW2, 011 ICW3, 100 ICW4,
//                   101 OCW1, 110 OCW2, 111 OCW3
//   cmd_stb    out  one-cycle pulse when cadr becomes valid
//   init_done  out  initialization complete; OCWs are accepted
//   sngl       out  SNGL bit latched from ICW1 (din[1])
//   ic4        out  IC4 bit latched from ICW1 (din[0])
//   seq_err    out  one-cycle pulse on an ignored or out-of-order write
// -----------------------------------------------------------------------------
module pic_cmd_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       CSn,
    input  logic       A0,
    input  logic [7:0] din,
    output logic [2:0] cadr,
    output logic       cmd_stb,
    output logic       init_done,
    output logic       sngl,
    output logic       ic4,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ICW2 = 3'd1,
        S_W_ICW3 = 3'd2,
        S_W_ICW4 = 3'd3,
        S_READY  = 3'd4
    } state_t;

    localparam logic [2:0] CA_NONE = 3'b000;
    localparam logic [2:0] CA_ICW1 = 3'b001;
    localparam logic [2:0] CA_ICW2 = 3'b010;
    localparam logic [2:0] CA_ICW3 = 3'b011;
    localparam logic [2:0] CA_ICW4 = 3'b100;
    localparam logic [2:0] CA_OCW1 = 3'b101;
    localparam logic [2:0] CA_OCW2 = 3'b110;
    localparam logic [2:0] CA_OCW3 = 3'b111;

    // Write-cycle capture registers
    logic       wr_act_reg;
    logic       wr_prev_reg;
    logic       a0_reg;
    logic [7:0] din_reg;

    // FSM and output registers
    state_t     state_reg, state_next;
    logic [2:0] cadr_reg, cadr_next;
    logic       cmd_stb_reg, cmd_stb_next;
    logic       seq_err_reg, seq_err_next;
    logic       init_done_reg, init_done_next;
    logic       sngl_reg, sngl_next;
    logic       ic4_reg, ic4_next;

    logic       ev;
    logic       is_icw1;

    // One event per strobe: rising edge of the registered write-active flag.
    assign ev      = wr_act_reg & ~wr_prev_reg;
    // ICW1 is recognised in every state and always restarts initialization.
    assign is_icw1 = ~a0_reg & din_reg[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_act_reg    <= 1'b0;
            wr_prev_reg   <= 1'b0;
            a0_reg        <= 1'b0;
            din_reg       <= 8'h00;
            state_reg     <= S_IDLE;
            cadr_reg      <= CA_NONE;
            cmd_stb_reg   <= 1'b0;
            seq_err_reg   <= 1'b0;
            init_done_reg <= 1'b0;
            sngl_reg      <= 1'b0;
            ic4_reg       <= 1'b0;
        end else begin
            wr_act_reg    <= ~wrn & ~CSn;
            wr_prev_reg   <= wr_act_reg;
            a0_reg        <= A0;
            din_reg       <= din;
            state_reg     <= state_next;
            cadr_reg      <= cadr_next;
            cmd_stb_reg   <= cmd_stb_next;
            seq_err_reg   <= seq_err_next;
            init_done_reg <= init_done_next;
            sngl_reg      <= sngl_next;
            ic4_reg       <= ic4_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_done_next = init_done_reg;
        sngl_next      = sngl_reg;
        ic4_next       = ic4_reg;
        cmd_stb_next   = 1'b0;
        seq_err_next   = 1'b0;
        // Without an event, cadr holds while the strobe is active and clears
        // on the clock after it ends (including CSn rising mid-strobe).
        cadr_next      = wr_act_reg ? cadr_reg : CA_NONE;

        if (ev) begin
            cadr_next    = CA_NONE;
            cmd_stb_next = 1'b1;
            if (is_icw1) begin
                cadr_next      = CA_ICW1;
                sngl_next      = din_reg[1];
                ic4_next       = din_reg[0];
                init_done_next = 1'b0;
                state_next     = S_W_ICW2;
            end else begin
                unique case (state_reg)
                    S_W_ICW2: begin
                        if (a0_reg) begin
                            cadr_next = CA_ICW2;
                            // ICW3 only exists in cascade mode (SNGL=0).
                            if (!sngl_reg) begin
                                state_next = S_W_ICW3;
                            end else if (ic4_reg) begin
                                state_next = S_W_ICW4;
                            end else begin
                                state_next     = S_READY;
                                init_done_next = 1'b1;
                            end
                        end else begin
                            cmd_stb_next = 1'b0;
                            seq_err_next = 1'b1;
                        end
                    end
                    S_W_ICW3: begin
                        if (a0_reg) begin
                            cadr_next = CA_ICW3;
                            if (ic4_reg) begin
                                state_next = S_W_ICW4;
                            end else begin
                                state_next     = S_READY;
                                init_done_next = 1'b1;
                            end
                        end else begin
                            cmd_stb_next = 1'b0;
                            seq_err_next = 1'b1;
                        end
                    end
                    S_W_ICW4: begin
                        if (a0_reg) begin
                            cadr_next      = CA_ICW4;
                            state_next     = S_READY;
                            init_done_next = 1'b1;
                        end else begin
                            cmd_stb_next = 1'b0;
                            seq_err_next = 1'b1;
                        end
                    end
                    S_READY: begin
                        // din[4]=1 with A0=0 was taken as ICW1 above, so
                        // only din[3] distinguishes OCW2 from OCW3 here.
                        if (a0_reg) begin
                            cadr_next = CA_OCW1;
                        end else if (!din_reg[3]) begin
                            cadr_next = CA_OCW2;
                        end else begin
                            cadr_next = CA_OCW3;
                        end
                    end
                    default: begin
                        // IDLE: only ICW1 is meaningful before initialization.
                        cmd_stb_next = 1'b0;
                        seq_err_next = 1'b1;
                    end
                endcase
            end
        end
    end

    assign cadr      = cadr_reg;
    assign cmd_stb   = cmd_stb_reg;
    assign seq_err   = seq_err_reg;
    assign init_done = init_done_reg;
    assign sngl      = sngl_reg;
    assign ic4       = ic4_reg;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_cmd_sequencer
//
// Table of write transactions with hand-derived expected decode results.
// Expected records are queued when a strobe is driven. A monitor pops and
// compares one record each time the DUT pulses cmd_stb or seq_err. Hand-written
// sequences cover CSn dropping mid-strobe, deselected strobes and reset during
// a held strobe.
// -----------------------------------------------------------------------------
module tb_pic_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       wrn;
    logic       CSn;
    logic       A0;
    logic [7:0] din;
    logic [2:0] cadr;
    logic       cmd_stb;
    logic       init_done;
    logic       sngl;
    logic       ic4;
    logic       seq_err;

    pic_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .wrn       (wrn),
        .CSn       (CSn),
        .A0        (A0),
        .din       (din),
        .cadr      (cadr),
        .cmd_stb   (cmd_stb),
        .init_done (init_done),
        .sngl      (sngl),
        .ic4       (ic4),
        .seq_err   (seq_err)
    );

    typedef struct {
        logic [2:0] cadr;
        logic       err;
        logic       init;
        logic       sngl;
        logic       ic4;
    } exp_t;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        int         len;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_stb = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mke(input logic [2:0] c, input logic er, input logic in,
                                 input logic s, input logic i4);
        exp_t e;
        e.cadr = c; e.err = er; e.init = in; e.sngl = s; e.ic4 = i4;
        return e;
    endfunction

    function automatic vec_t mkv(input logic a0, input logic [7:0] d, input int len,
                                 input exp_t e);
        vec_t v;
        v.a0 = a0; v.d = d; v.len = len; v.e = e;
        return v;
    endfunction

    // Scoreboard monitor: one record per decoded write.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (prev_stb) chk("stb_width", int'(cmd_stb), 0);
        prev_stb = cmd_stb;
        if (cmd_stb || seq_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_decode: cadr=%0d cmd_stb=%0b seq_err=%0b, none expected",
                         cadr, cmd_stb, seq_err);
            end else begin
                e = sb.pop_front();
                $display("txn t=%0t cadr=%0d stb=%0b err=%0b init=%0b sngl=%0b ic4=%0b",
                         $time, cadr, cmd_stb, seq_err, init_done, sngl, ic4);
                chk("cadr",      int'(cadr),      int'(e.cadr));
                chk("cmd_stb",   int'(cmd_stb),   int'(!e.err));
                chk("seq_err",   int'(seq_err),   int'(e.err));
                chk("init_done", int'(init_done), int'(e.init));
                chk("sngl",      int'(sngl),      int'(e.sngl));
                chk("ic4",       int'(ic4),       int'(e.ic4));
            end
        end
    end

    // Drive one strobe of len clocks, then an idle gap of two clocks.
    task automatic wr(input logic a0v, input logic [7:0] d, input int len, input exp_t e);
        @(negedge clk);
        sb.push_back(e);
        wrn = 1'b0; CSn = 1'b0; A0 = a0v; din = d;
        repeat (len) @(negedge clk);
        chk("cadr_hold", int'(cadr), int'(e.cadr));
        chk("decoded_in_time", sb.size(), 0);
        wrn = 1'b1; CSn = 1'b1;
        repeat (2) @(negedge clk);
        chk("cadr_idle", int'(cadr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wrn = 1'b1; CSn = 1'b1; A0 = 1'b0; din = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("rst_cadr",      int'(cadr),      0);
        chk("rst_cmd_stb",   int'(cmd_stb),   0);
        chk("rst_seq_err",   int'(seq_err),   0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_sngl",      int'(sngl),      0);
        chk("rst_ic4",       int'(ic4),       0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        //            a0    din    len  cadr    err  init sngl ic4
        tbl.push_back(mkv(1'b1, 8'h00, 3, mke(3'd0, 1, 0, 0, 0))); // IDLE, A0=1
        tbl.push_back(mkv(1'b0, 8'h08, 4, mke(3'd0, 1, 0, 0, 0))); // IDLE, non-ICW1
        tbl.push_back(mkv(1'b0, 8'h13, 3, mke(3'd1, 0, 0, 1, 1))); // ICW1 SNGL IC4
        tbl.push_back(mkv(1'b0, 8'h08, 3, mke(3'd0, 1, 0, 1, 1))); // W_ICW2 bad
        tbl.push_back(mkv(1'b1, 8'hAA, 5, mke(3'd2, 0, 0, 1, 1))); // ICW2
        tbl.push_back(mkv(1'b0, 8'h04, 3, mke(3'd0, 1, 0, 1, 1))); // W_ICW4 bad
        tbl.push_back(mkv(1'b1, 8'h01, 3, mke(3'd4, 0, 1, 1, 1))); // ICW4
        tbl.push_back(mkv(1'b0, 8'h10, 3, mke(3'd1, 0, 0, 0, 0))); // ICW1 cascade
        tbl.push_back(mkv(1'b1, 8'h55, 3, mke(3'd2, 0, 0, 0, 0))); // ICW2
        tbl.push_back(mkv(1'b1, 8'h66, 4, mke(3'd3, 0, 1, 0, 0))); // ICW3
        tbl.push_back(mkv(1'b1, 8'h55, 3, mke(3'd5, 0, 1, 0, 0))); // OCW1
        tbl.push_back(mkv(1'b0, 8'h20, 3, mke(3'd6, 0, 1, 0, 0))); // OCW2
        tbl.push_back(mkv(1'b0, 8'h0B, 3, mke(3'd7, 0, 1, 0, 0))); // OCW3
        tbl.push_back(mkv(1'b0, 8'h12, 3, mke(3'd1, 0, 0, 1, 0))); // ICW1 from READY
        tbl.push_back(mkv(1'b1, 8'h00, 3, mke(3'd2, 0, 1, 1, 0))); // ICW2 -> READY
        tbl.push_back(mkv(1'b0, 8'h08, 3, mke(3'd7, 0, 1, 1, 0))); // OCW3 in READY

        foreach (tbl[i]) wr(tbl[i].a0, tbl[i].d, tbl[i].len, tbl[i].e);

        // CSn rises mid-strobe: cadr clears one clock later, decode stands.
        @(negedge clk);
        sb.push_back(mke(3'd5, 0, 1, 1, 0));
        wrn = 1'b0; CSn = 1'b0; A0 = 1'b1; din = 8'h00;
        repeat (2) @(negedge clk);
        CSn = 1'b1;
        @(negedge clk);
        chk("csn_mid_cadr_hold", int'(cadr), 5);
        @(negedge clk);
        chk("csn_mid_cadr_clear", int'(cadr), 0);
        wrn = 1'b1;
        repeat (2) @(negedge clk);
        chk("csn_mid_decoded", sb.size(), 0);

        // Deselected strobe carrying an ICW1 pattern: nothing happens.
        @(negedge clk);
        wrn = 1'b0; CSn = 1'b1; A0 = 1'b0; din = 8'h13;
        repeat (4) @(negedge clk);
        chk("desel_cadr", int'(cadr), 0);
        chk("desel_init_done", int'(init_done), 1);
        wrn = 1'b1;
        repeat (2) @(negedge clk);
        wr(1'b1, 8'h00, 3, mke(3'd5, 0, 1, 1, 0)); // still READY

        // Reset during W_ICW3 with the strobe held low.
        wr(1'b0, 8'h11, 3, mke(3'd1, 0, 0, 0, 1));
        wr(1'b1, 8'h00, 3, mke(3'd2, 0, 0, 0, 1));
        @(negedge clk);
        wrn = 1'b0; CSn = 1'b0; A0 = 1'b1; din = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("midrst_ic4",       int'(ic4),       0);
        chk("midrst_cadr",      int'(cadr),      0);
        chk("midrst_init_done", int'(init_done), 0);
        chk("midrst_seq_err",   int'(seq_err),   0);
        repeat (2) @(negedge clk);
        sb.push_back(mke(3'd0, 1, 0, 0, 0)); // fresh event decoded from IDLE
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_event", sb.size(), 0);
        wrn = 1'b1; CSn = 1'b1;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
